// File: rtl/cdb_pkg.sv
// Shared types, defaults and helpers for the common data bus arbiter.
package cdb_pkg;

    localparam int CDB_DATA_WIDTH          = 32;
    localparam int CDB_PHYS_REG_ADDR_WIDTH = 6;
    localparam int CDB_NUM_SRC             = 4;
    localparam int CDB_NUM_CDB             = 3;
    localparam int CDB_FIFO_DEPTH          = 2;

    // One buffered result at default widths.
    typedef struct packed {
        logic [CDB_DATA_WIDTH-1:0]          data;
        logic [CDB_PHYS_REG_ADDR_WIDTH-1:0] dest_reg;
    } cdb_entry_t;

    // Source tag width; a single source still needs one bit.
    function automatic int tag_width(input int num_src);
        return (num_src <= 1) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer. Flush wins over push and pop; full rejects a
// push even when the same edge pops.
module cdb_src_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    // A depth-1 FIFO keeps its pointers parked at slot 0.
    localparam logic [AW-1:0] PTR_STEP = (DEPTH > 1) ? AW'(1) : AW'(0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; flush empties the buffer outright.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_STEP;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_STEP;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers NUM_SRC producers and broadcasts up to
// NUM_CDB of them per cycle onto registered channels, round-robin fair.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_WIDTH          = CDB_DATA_WIDTH,
    parameter int PHYS_REG_ADDR_WIDTH = CDB_PHYS_REG_ADDR_WIDTH,
    parameter int NUM_SRC             = CDB_NUM_SRC,
    parameter int NUM_CDB             = CDB_NUM_CDB,
    parameter int FIFO_DEPTH          = CDB_FIFO_DEPTH,
    localparam int TAG_WIDTH          = tag_width(NUM_SRC)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic [NUM_SRC-1:0]                     src_valid,
    output logic [NUM_SRC-1:0]                     src_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]          src_data,
    input  logic [NUM_SRC*PHYS_REG_ADDR_WIDTH-1:0] src_dest_reg,
    output logic [NUM_CDB-1:0]                     cdb_valid,
    output logic [NUM_CDB*TAG_WIDTH-1:0]           cdb_tag,
    output logic [NUM_CDB*DATA_WIDTH-1:0]          cdb_data,
    output logic [NUM_CDB*PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg
);

    localparam int EW = DATA_WIDTH + PHYS_REG_ADDR_WIDTH;

    if (NUM_CDB < 1 || NUM_CDB > NUM_SRC) begin : g_bad_cfg
        $error("cdb_arbiter: NUM_CDB must be within 1..NUM_SRC");
    end

    logic [NUM_SRC-1:0]          full;
    logic [NUM_SRC-1:0]          empty;
    logic [NUM_SRC-1:0]          grant;
    logic [NUM_SRC-1:0][EW-1:0]  head;
    logic [TAG_WIDTH-1:0]        rr_ptr;
    logic [TAG_WIDTH-1:0]        rr_next;
    logic [NUM_CDB-1:0]          win_vld;
    logic [NUM_CDB-1:0][TAG_WIDTH-1:0] win_tag;

    assign src_ready = ~full;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (src_valid[i]),
            .pop   (grant[i]),
            .wdata ({src_data[i*DATA_WIDTH +: DATA_WIDTH],
                     src_dest_reg[i*PHYS_REG_ADDR_WIDTH +: PHYS_REG_ADDR_WIDTH]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // Scan from rr_ptr; the k-th non-empty source found takes channel k.
    always_comb begin
        int cnt;
        int idx;
        int last;
        win_vld = '0;
        win_tag = '0;
        grant   = '0;
        cnt     = 0;
        idx     = 0;
        last    = int'(rr_ptr);
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = (int'(rr_ptr) + j) % NUM_SRC;
            if (!empty[idx] && cnt < NUM_CDB) begin
                win_vld[cnt] = 1'b1;
                win_tag[cnt] = TAG_WIDTH'(idx);
                grant[idx]   = 1'b1;
                last         = idx;
                cnt++;
            end
        end
        rr_next = (cnt > 0) ? TAG_WIDTH'((last + 1) % NUM_SRC) : rr_ptr;
    end

    // Broadcast registers; idle channels are driven fully to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            cdb_valid    <= '0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_dest_reg <= '0;
        end else if (flush) begin
            rr_ptr       <= '0;
            cdb_valid    <= '0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_dest_reg <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k] <= win_vld[k];
                if (win_vld[k]) begin
                    cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]  <= win_tag[k];
                    cdb_data[k*DATA_WIDTH +: DATA_WIDTH] <=
                        head[win_tag[k]][EW-1 -: DATA_WIDTH];
                    cdb_dest_reg[k*PHYS_REG_ADDR_WIDTH +: PHYS_REG_ADDR_WIDTH] <=
                        head[win_tag[k]][PHYS_REG_ADDR_WIDTH-1:0];
                end else begin
                    cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]  <= '0;
                    cdb_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    cdb_dest_reg[k*PHYS_REG_ADDR_WIDTH +: PHYS_REG_ADDR_WIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: default 4x3 instance plus a 4x1 instance
// that exercises backpressure against a per-source scoreboard.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [3:0]   src_valid;
    logic [127:0] src_data;
    logic [23:0]  src_dest_reg;

    logic [3:0]   src_ready;
    logic [2:0]   cdb_valid;
    logic [5:0]   cdb_tag;
    logic [95:0]  cdb_data;
    logic [17:0]  cdb_dest_reg;

    logic [3:0]   src_ready1;
    logic [0:0]   cdb_valid1;
    logic [1:0]   cdb_tag1;
    logic [31:0]  cdb_data1;
    logic [5:0]   cdb_dest1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .src_dest_reg(src_dest_reg),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_dest_reg(cdb_dest_reg)
    );

    cdb_arbiter #(.NUM_CDB(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready1),
        .src_data(src_data), .src_dest_reg(src_dest_reg),
        .cdb_valid(cdb_valid1), .cdb_tag(cdb_tag1),
        .cdb_data(cdb_data1), .cdb_dest_reg(cdb_dest1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        flush        = 1'b0;
        src_valid    = '0;
        src_data     = '0;
        src_dest_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [31:0] sb_q [4][$];
    int          seq [4];
    logic [3:0]  acc;
    logic [5:0]  et;
    logic [31:0] ev;
    bit          saw_bp;
    int          n_acc;
    int          n_bc;

    task automatic observe_dut1();
        if (cdb_valid1[0]) begin
            n_bc++;
            if (sb_q[cdb_tag1].size() == 0) begin
                chk("t5_unexpected", 1, 0);
            end else begin
                ev = sb_q[cdb_tag1].pop_front();
                chk("t5_data", cdb_data1, ev);
                chk("t5_dest", cdb_dest1, ev[5:0]);
            end
        end
    endtask

    initial begin
        // 1: reset state
        reset = 1'b0; flush = 1'b0; src_valid = '0; src_data = '0; src_dest_reg = '0;
        @(posedge clk); #1;
        chk("t1_valid", cdb_valid, 3'b000);
        chk("t1_ready", src_ready, 4'b1111);
        chk("t1_fields", {cdb_tag, cdb_data, cdb_dest_reg}, '0);
        reset = 1'b1;

        // 2: single result, two-cycle latency, one-cycle pulse
        do_reset();
        src_valid = 4'b0010;
        src_data[63:32] = 32'hDEADBEEF;
        src_dest_reg[11:6] = 6'd5;
        step();
        src_valid = '0;
        chk("t2_c1_valid", cdb_valid, 3'b000);
        step();
        chk("t2_c2_valid", cdb_valid, 3'b001);
        chk("t2_c2_tag", cdb_tag[1:0], 2'd1);
        chk("t2_c2_data", cdb_data[31:0], 32'hDEADBEEF);
        chk("t2_c2_dest", cdb_dest_reg[5:0], 6'd5);
        step();
        chk("t2_c3_valid", cdb_valid, 3'b000);

        // 3: four results at once, fourth spills to next cycle
        do_reset();
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            src_data[i*32 +: 32]   = 32'h10 + i;
            src_dest_reg[i*6 +: 6] = 6'(i);
        end
        step();
        src_valid = '0;
        step();
        chk("t3_c2_valid", cdb_valid, 3'b111);
        chk("t3_c2_tag", cdb_tag, {2'd2, 2'd1, 2'd0});
        chk("t3_c2_data", cdb_data, {32'h12, 32'h11, 32'h10});
        chk("t3_c2_dest", cdb_dest_reg, {6'd2, 6'd1, 6'd0});
        step();
        chk("t3_c3_valid", cdb_valid, 3'b001);
        chk("t3_c3_tag", cdb_tag, 6'b000011);
        chk("t3_c3_data", cdb_data, {64'h0, 32'h13});
        chk("t3_c3_dest", cdb_dest_reg[5:0], 6'd3);
        chk("t3_rr_ptr", dut.rr_ptr, 2'd0);

        // 4: saturated rotation {0,1,2},{3,0,1},{2,3,0},{1,2,3}
        do_reset();
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'h100 + i;
        step();
        step();
        begin
            int gcnt [4];
            for (int i = 0; i < 4; i++) gcnt[i] = 0;
            for (int c = 2; c < 10; c++) begin
                for (int k = 0; k < 3; k++) et[k*2 +: 2] = 2'((3*(c-2) + k) % 4);
                chk("t4_valid", cdb_valid, 3'b111);
                chk("t4_tag", cdb_tag, et);
                for (int k = 0; k < 3; k++) gcnt[cdb_tag[k*2 +: 2]]++;
                step();
            end
            for (int i = 0; i < 4; i++) chk("t4_grants", gcnt[i], 6);
        end
        // asynchronous reset mid-broadcast clears outputs at once
        #2;
        reset = 1'b0;
        #1;
        chk("t4_async_valid", cdb_valid, 3'b000);
        chk("t4_async_fields", {cdb_tag, cdb_data, cdb_dest_reg}, '0);
        chk("t4_async_ready", src_ready, 4'b1111);

        // 6: flush drops buffered entries and the same-cycle push
        do_reset();
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'h20 + i;
        step();
        for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'h30 + i;
        step();
        flush = 1'b1;
        for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'hBAD;
        step();
        flush = 1'b0;
        src_valid = '0;
        chk("t6_valid", cdb_valid, 3'b000);
        chk("t6_fields", {cdb_tag, cdb_data, cdb_dest_reg}, '0);
        chk("t6_ready", src_ready, 4'b1111);
        chk("t6_rr_ptr", dut.rr_ptr, 2'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t6_quiet", cdb_valid, 3'b000);
        end

        // 5: single channel backpressure with scoreboard
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            sb_q[i].delete();
        end
        acc = '0; saw_bp = 1'b0; n_acc = 0; n_bc = 0;
        src_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            observe_dut1();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) seq[i]++;
                src_data[i*32 +: 32]   = {8'(i), 24'(seq[i])};
                src_dest_reg[i*6 +: 6] = 6'(seq[i]);
            end
            if (src_ready1 != 4'b1111) saw_bp = 1'b1;
            acc = src_valid & src_ready1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    sb_q[i].push_back({8'(i), 24'(seq[i])});
                    n_acc++;
                end
            end
            step();
        end
        src_valid = '0;
        acc = '0;
        for (int c = 0; c < 16; c++) begin
            observe_dut1();
            step();
        end
        chk("t5_backpressure", saw_bp, 1'b1);
        for (int i = 0; i < 4; i++) chk("t5_drained", sb_q[i].size(), 0);
        chk("t5_count", n_bc, n_acc);
        chk("t5_ready_end", src_ready1, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Parametrised Common Data Bus arbiter and broadcaster for the superscalar Tomasulo core. It collects completed results from NUM_SRC functional units, buffers each source in a small FIFO, and grants up to NUM_CDB broadcast channels per cycle using round-robin fairness. It drives registered CDB channels that reservation stations and the register file snoop. It replaces the fixed 3-unit/3-channel bus with M producers onto N channels, adding backpressure and flush.

Parameters:
DATA_WIDTH, 32, result data width
PHYS_REG_ADDR_WIDTH, 6, physical destination register address width
NUM_SRC, 4, number of producing functional units
NUM_CDB, 3, number of broadcast channels; must satisfy 1 <= NUM_CDB <= NUM_SRC (elaboration-time error otherwise)
FIFO_DEPTH, 2, per-source buffer entries; power of two, >= 1
TAG_WIDTH, $clog2(NUM_SRC) (minimum 1), source tag width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush (mispredict/exception)
src_valid  in  NUM_SRC  result valid per source
src_ready  out  NUM_SRC  source FIFO can accept
src_data  in  NUM_SRC*DATA_WIDTH  flattened result data; source i at [i*DATA_WIDTH +: DATA_WIDTH]
src_dest_reg  in  NUM_SRC*PHYS_REG_ADDR_WIDTH  flattened destination physical register
cdb_valid  out  NUM_CDB  channel k carries a valid broadcast
cdb_tag  out  NUM_CDB*TAG_WIDTH  index of the originating source
cdb_data  out  NUM_CDB*DATA_WIDTH  broadcast data
cdb_dest_reg  out  NUM_CDB*PHYS_REG_ADDR_WIDTH  broadcast destination register

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs empty; rr_ptr=0; cdb_valid, cdb_tag, cdb_data and cdb_dest_reg all 0; src_ready all 1 (combinational from empty FIFOs).
- Push: src i is written on a rising edge when src_valid[i] && src_ready[i]. src_ready[i] = !full[i]. It depends only on occupancy and is conservative: a full FIFO rejects a push even when it pops in the same cycle.
- Arbitration (combinational on FIFO heads each cycle): scan sources rr_ptr, rr_ptr+1, ... mod NUM_SRC. The first NUM_CDB non-empty sources win, in scan order. The k-th winner goes to channel k. Winners are popped at the edge.
- rr_ptr update: becomes (index of last winner + 1) mod NUM_SRC. Unchanged if nothing is granted.
- Output registers: at each edge, channel k loads {1, winner tag, head data, head dest}. Channels without a winner load valid=0 with tag, data and dest all 0.
- Latency: a result presented at cycle 0 into an empty FIFO with no contention is visible on the CDB in cycle 2. Each broadcast is valid for exactly one cycle; there is no CDB-side stall.
- Per-source order is preserved (FIFO). There is no ordering guarantee across sources.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- flush=1 at an edge: all FIFOs are emptied; pushes in the same cycle are dropped; rr_ptr=0; all cdb_valid=0 next cycle, with tag, data and dest zeroed. Flush has priority over push and pop.
- Reset asserted mid-operation clears all state immediately, including in-flight broadcasts.

Decomposition:
- Package cdb_pkg holds:
  - cdb_entry_t packed struct {data, dest_reg}, parametrised via the package defaults DATA_WIDTH/PHYS_REG_ADDR_WIDTH
  - a tag-width helper function
  - default localparams
- Sub-module cdb_src_fifo: one per source via generate. Push/pop/flush, full/empty, head output.
- Arbiter scan and output registers live in cdb_arbiter.

Test Plan:
1. Reset with default parameters -> cdb_valid=3'b000, src_ready=4'b1111, all cdb fields 0.
2. Cycle 0: src1 valid, data 0xDEADBEEF, dest 5 -> cycle 2: cdb_valid=3'b001, tag0=1, data0=0xDEADBEEF, dest0=5; cycle 3: cdb_valid=0.
3. Cycle 0: all 4 sources valid once (data 0x10..0x13) -> cycle 2: channels 0/1/2 carry tags 0/1/2; cycle 3: channel 0 carries tag 3 (data 0x13), rr_ptr=0 afterwards.
4. All 4 sources held valid continuously -> grant sets rotate {0,1,2}, {3,0,1}, {2,3,0}. No source is starved, and each source gets 3 grants per 4 cycles.
5. Backpressure with NUM_CDB=1, FIFO_DEPTH=2, sources 0–3 held valid -> src_ready deasserts once the FIFOs are full. No accepted result is lost or duplicated; a scoreboard compares accepted vs. broadcast per source.
6. Several FIFOs holding entries, flush pulsed for 1 cycle -> next cycle cdb_valid=0 and src_ready all 1. No pre-flush entry is ever broadcast. A push presented in the flush cycle is dropped.
